// File: rtl/hash_result_scanner.sv
// Scans NUM_NONCES consecutive hash words from memory and reports
// the first word below target and the minimum word seen.
module hash_result_scanner #(
  parameter int NUM_NONCES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] output_addr,
  input  logic [31:0] target,
  output logic        done,
  output logic        mem_clk,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data,
  output logic        found,
  output logic [3:0]  found_nonce,
  output logic [31:0] min_hash,
  output logic [3:0]  min_nonce
);

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    SCAN,
    FIN
  } state_t;

  localparam logic [3:0] LAST = 4'(NUM_NONCES - 1);
  localparam logic [4:0] NN   = 5'(NUM_NONCES);

  state_t      state;
  logic [15:0] base_q;
  logic [31:0] target_q;
  logic [3:0]  idx;
  logic [4:0]  k2;
  logic        more;
  logic [15:0] next_addr;

  assign mem_clk        = clk;
  assign mem_we         = 1'b0;
  assign mem_write_data = 32'd0;

  // Address of the word fetched two captures ahead of the current one.
  assign k2        = {1'b0, idx} + 5'd2;
  assign more      = k2 < NN;
  assign next_addr = base_q + {12'd0, idx} + 16'd2;

  // Scan sequencer, address generator and result accumulation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      base_q      <= 16'd0;
      target_q    <= 32'd0;
      idx         <= 4'd0;
      mem_addr    <= 16'd0;
      done        <= 1'b0;
      found       <= 1'b0;
      found_nonce <= 4'd0;
      min_hash    <= 32'd0;
      min_nonce   <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            base_q      <= output_addr;
            target_q    <= target;
            mem_addr    <= output_addr;
            idx         <= 4'd0;
            found       <= 1'b0;
            found_nonce <= 4'd0;
            min_hash    <= 32'd0;
            min_nonce   <= 4'd0;
            state       <= PRIME;
          end
        end
        PRIME: begin
          mem_addr <= base_q + 16'd1;
          state    <= SCAN;
        end
        SCAN: begin
          if (!found && (mem_read_data < target_q)) begin
            found       <= 1'b1;
            found_nonce <= idx;
          end
          if ((idx == 4'd0) || (mem_read_data < min_hash)) begin
            min_hash  <= mem_read_data;
            min_nonce <= idx;
          end
          if (idx == LAST) begin
            done  <= 1'b1;
            state <= FIN;
          end else begin
            idx <= idx + 4'd1;
            if (more) mem_addr <= next_addr;
          end
        end
        FIN: begin
          if (!start) begin
            done  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
